// File: rtl/ex_hazard_alu_if.sv
// Bus between the ID stage, the EX-stage slice and the MEM/WB stages.
// The stage upstream drives master. The execute slice is the slave.
interface ex_hazard_alu_if;
  logic [31:0] id_ir;
  logic [3:0]  id_aluop;
  logic [31:0] id_rfd1;
  logic [31:0] id_rfd2;
  logic [31:0] id_imm;
  logic [31:0] wb_data;
  logic        flush;
  logic        hold;
  logic        stall;
  logic [31:0] ex_result;
  logic [31:0] ex_r2;
  logic        ex_of;
  logic        ex_uof;
  logic        ex_equal;
  logic [31:0] mem_ir;
  logic [31:0] mem_aluout;
  logic [31:0] mem_store_data;

  modport master (
    output id_ir, id_aluop, id_rfd1, id_rfd2, id_imm, wb_data, flush, hold,
    input  stall, ex_result, ex_r2, ex_of, ex_uof, ex_equal,
    input  mem_ir, mem_aluout, mem_store_data
  );

  modport slave (
    input  id_ir, id_aluop, id_rfd1, id_rfd2, id_imm, wb_data, flush, hold,
    output stall, ex_result, ex_r2, ex_of, ex_uof, ex_equal,
    output mem_ir, mem_aluout, mem_store_data
  );
endinterface

// File: rtl/ex_hazard_alu.sv
// MIPS execute-stage slice: hazard detection, ID/EX and EX/MEM registers,
// operand forwarding and the ALU.
module ex_hazard_alu (
  input  logic           clk,
  input  logic           rst,
  ex_hazard_alu_if.slave bus
);

  typedef struct packed {
    logic [4:0] a_idx;
    logic       a_used;
    logic [4:0] b_idx;
    logic       b_used;
    logic [4:0] s_idx;
    logic       s_used;
  } src_t;

  function automatic src_t src_decode(input logic [31:0] ir);
    src_t d;
    d = '0;
    if (ir[31:26] == 6'h00) begin
      case (ir[5:0])
        6'h00, 6'h02, 6'h03: begin d.a_idx = ir[20:16]; d.a_used = 1'b1; end
        6'h04, 6'h06, 6'h07: begin
          d.a_idx = ir[20:16]; d.a_used = 1'b1;
          d.b_idx = ir[25:21]; d.b_used = 1'b1;
        end
        6'h0C: begin
          d.a_idx = 5'd2; d.a_used = 1'b1;
          d.b_idx = 5'd4; d.b_used = 1'b1;
        end
        6'h08: begin d.a_idx = ir[25:21]; d.a_used = 1'b1; end
        default: begin
          d.a_idx = ir[25:21]; d.a_used = 1'b1;
          d.b_idx = ir[20:16]; d.b_used = 1'b1;
        end
      endcase
    end else if ((ir[31:26] >= 6'h08 && ir[31:26] <= 6'h0F) ||
                 (ir[31:26] >= 6'h20 && ir[31:26] <= 6'h2B)) begin
      d.a_idx = ir[25:21]; d.a_used = 1'b1;
      if (ir[31:26] >= 6'h28) begin
        d.s_idx = ir[20:16]; d.s_used = 1'b1;
      end else begin
        d.s_used = 1'b0;
      end
    end else if (ir[31:26] == 6'h04 || ir[31:26] == 6'h05) begin
      d.a_idx = ir[25:21]; d.a_used = 1'b1;
      d.b_idx = ir[20:16]; d.b_used = 1'b1;
    end else begin
      d = '0;
    end
    return d;
  endfunction

  function automatic logic b_is_imm(input logic [31:0] ir);
    if (ir[31:26] == 6'h00) begin
      return (ir[5:0] == 6'h00 || ir[5:0] == 6'h02 || ir[5:0] == 6'h03);
    end else begin
      return (ir[31:26] >= 6'h08 && ir[31:26] <= 6'h0F) ||
             (ir[31:26] >= 6'h20 && ir[31:26] <= 6'h2B);
    end
  endfunction

  function automatic logic [4:0] dest_of(input logic [31:0] ir);
    if (ir[31:26] == 6'h00) begin
      return (ir[5:0] == 6'h08 || ir[5:0] == 6'h0C) ? 5'd0 : ir[15:11];
    end else if (ir[31:26] >= 6'h08 && ir[31:26] <= 6'h25 &&
                 !(ir[31:26] >= 6'h10 && ir[31:26] <= 6'h1F)) begin
      return ir[20:16];
    end else if (ir[31:26] == 6'h03) begin
      return 5'd31;
    end else begin
      return 5'd0;
    end
  endfunction

  // Register 0 is never a real producer, so an index of 0 never forwards
  function automatic logic [1:0] fwd_sel(input logic used, input logic [4:0] idx,
                                         input logic [4:0] ex_dest, input logic [4:0] mem_dest);
    if (!used || idx == 5'd0) return 2'b00;
    else if (idx == ex_dest)  return 2'b01;
    else if (idx == mem_dest) return 2'b10;
    else                      return 2'b00;
  endfunction

  function automatic logic [31:0] fwd_val(input logic [1:0] sel, input logic [31:0] rf,
                                          input logic [31:0] mem, input logic [31:0] wb);
    case (sel)
      2'b01:   return mem;
      2'b10:   return wb;
      default: return rf;
    endcase
  endfunction

  logic [31:0] ex_ir_r, rfd1_r, rfd2_r, imm_r;
  logic [3:0]  aluop_r;
  logic [1:0]  sel_a_r, sel_b_r, sel_st_r;
  logic [31:0] mem_ir_r, mem_aluout_r, mem_store_data_r;

  src_t        id_src_s;
  logic [4:0]  ex_dest_s, mem_dest_s;
  logic [1:0]  sel_a_s, sel_b_s, sel_st_s;
  logic        ex_is_load_s, stall_s;
  logic [31:0] op_a_s, op_b_s, store_s;
  logic [4:0]  shamt_s;
  logic [32:0] add_s, sub_s;
  logic [63:0] prod_s;
  logic [31:0] alu_r_s, alu_r2_s;
  logic        of_s, uof_s;

  assign id_src_s     = src_decode(bus.id_ir);
  assign ex_dest_s    = dest_of(ex_ir_r);
  assign mem_dest_s   = dest_of(mem_ir_r);
  assign sel_a_s      = fwd_sel(id_src_s.a_used, id_src_s.a_idx, ex_dest_s, mem_dest_s);
  assign sel_b_s      = fwd_sel(id_src_s.b_used, id_src_s.b_idx, ex_dest_s, mem_dest_s);
  assign sel_st_s     = fwd_sel(id_src_s.s_used, id_src_s.s_idx, ex_dest_s, mem_dest_s);
  assign ex_is_load_s = (ex_ir_r[31:26] >= 6'h20) && (ex_ir_r[31:26] <= 6'h25);
  // A select of 01 means the EX producer matches a source the ID instruction uses
  assign stall_s      = ex_is_load_s &&
                        (sel_a_s == 2'b01 || sel_b_s == 2'b01 || sel_st_s == 2'b01);

  // ID/EX pipeline register with bubble insertion
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_ir_r  <= 32'd0; aluop_r <= 4'd0;
      rfd1_r   <= 32'd0; rfd2_r  <= 32'd0; imm_r <= 32'd0;
      sel_a_r  <= 2'b00; sel_b_r <= 2'b00; sel_st_r <= 2'b00;
    end else if (!bus.hold) begin
      if (stall_s || bus.flush) begin
        ex_ir_r  <= 32'd0; aluop_r <= 4'd0;
        rfd1_r   <= 32'd0; rfd2_r  <= 32'd0; imm_r <= 32'd0;
        sel_a_r  <= 2'b00; sel_b_r <= 2'b00; sel_st_r <= 2'b00;
      end else begin
        ex_ir_r  <= bus.id_ir;   aluop_r <= bus.id_aluop;
        rfd1_r   <= bus.id_rfd1; rfd2_r  <= bus.id_rfd2; imm_r <= bus.id_imm;
        sel_a_r  <= sel_a_s;     sel_b_r <= sel_b_s;     sel_st_r <= sel_st_s;
      end
    end
  end

  assign op_a_s  = fwd_val(sel_a_r, rfd1_r, mem_aluout_r, bus.wb_data);
  assign op_b_s  = b_is_imm(ex_ir_r) ? imm_r : fwd_val(sel_b_r, rfd2_r, mem_aluout_r, bus.wb_data);
  assign store_s = fwd_val(sel_st_r, rfd2_r, mem_aluout_r, bus.wb_data);
  assign shamt_s = op_b_s[4:0];
  assign add_s   = {1'b0, op_a_s} + {1'b0, op_b_s};
  assign sub_s   = {1'b0, op_a_s} - {1'b0, op_b_s};
  // Low 64 bits of the sign-extended product equal the signed 32x32 product
  assign prod_s  = {{32{op_a_s[31]}}, op_a_s} * {{32{op_b_s[31]}}, op_b_s};

  // ALU result and flags
  always_comb begin
    alu_r_s  = 32'd0;
    alu_r2_s = 32'd0;
    of_s     = 1'b0;
    uof_s    = 1'b0;
    case (aluop_r)
      4'd0: alu_r_s = op_a_s << shamt_s;
      4'd1: alu_r_s = $signed(op_a_s) >>> shamt_s;
      4'd2: alu_r_s = op_a_s >> shamt_s;
      4'd3: begin alu_r_s = prod_s[31:0]; alu_r2_s = prod_s[63:32]; end
      4'd4: begin
        if (op_b_s != 32'd0) begin
          alu_r_s  = op_a_s / op_b_s;
          alu_r2_s = op_a_s % op_b_s;
        end else begin
          alu_r_s  = 32'd0;
          alu_r2_s = 32'd0;
        end
      end
      4'd5: begin
        alu_r_s = add_s[31:0];
        uof_s   = add_s[32];
        of_s    = (op_a_s[31] == op_b_s[31]) && (add_s[31] != op_a_s[31]);
      end
      4'd6: begin
        alu_r_s = sub_s[31:0];
        uof_s   = sub_s[32];
        of_s    = (op_a_s[31] != op_b_s[31]) && (sub_s[31] != op_a_s[31]);
      end
      4'd7:  alu_r_s = op_a_s & op_b_s;
      4'd8:  alu_r_s = op_a_s | op_b_s;
      4'd9:  alu_r_s = op_a_s ^ op_b_s;
      4'd10: alu_r_s = ~(op_a_s | op_b_s);
      4'd11: alu_r_s = {31'd0, ($signed(op_a_s) < $signed(op_b_s))};
      4'd12: alu_r_s = {31'd0, (op_a_s < op_b_s)};
      default: alu_r_s = 32'd0;
    endcase
  end

  // EX/MEM pipeline register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_ir_r         <= 32'd0;
      mem_aluout_r     <= 32'd0;
      mem_store_data_r <= 32'd0;
    end else if (!bus.hold) begin
      mem_ir_r         <= ex_ir_r;
      mem_aluout_r     <= alu_r_s;
      mem_store_data_r <= store_s;
    end
  end

  assign bus.stall          = stall_s;
  assign bus.ex_result      = alu_r_s;
  assign bus.ex_r2          = alu_r2_s;
  assign bus.ex_of          = of_s;
  assign bus.ex_uof         = uof_s;
  assign bus.ex_equal       = (op_a_s == op_b_s);
  assign bus.mem_ir         = mem_ir_r;
  assign bus.mem_aluout     = mem_aluout_r;
  assign bus.mem_store_data = mem_store_data_r;

endmodule

// File: tb/tb_ex_hazard_alu.sv
// Directed and randomized checks of ex_hazard_alu against an architectural model.
module tb_ex_hazard_alu;
  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  ex_hazard_alu_if bus ();
  ex_hazard_alu dut (.clk(clk), .rst(rst), .bus(bus));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sh,
                                        input logic [5:0] fn);
    return {6'd0, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] im);
    return {op, rs, rt, im};
  endfunction

  task automatic issue(input logic [31:0] ir, input logic [3:0] aluop, input logic [31:0] r1,
                       input logic [31:0] r2, input logic [31:0] im);
    bus.id_ir = ir; bus.id_aluop = aluop; bus.id_rfd1 = r1; bus.id_rfd2 = r2; bus.id_imm = im;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    issue(32'd0, 4'd0, 32'd0, 32'd0, 32'd0);
    tick();
    tick();
  endtask

  // Architectural ALU: wide integer arithmetic, ranges checked numerically
  task automatic alu_ref(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                         output logic [31:0] r, output logic [31:0] r2,
                         output logic of, output logic uof, output logic eq);
    longint sx, sy, ux, uy, t;
    sx = longint'($signed(x)); sy = longint'($signed(y));
    ux = longint'({32'd0, x}); uy = longint'({32'd0, y});
    r = 32'd0; r2 = 32'd0; of = 1'b0; uof = 1'b0; eq = (x == y);
    case (op)
      4'd0: r = x << y[4:0];
      4'd1: begin t = sx >>> y[4:0]; r = t[31:0]; end
      4'd2: r = x >> y[4:0];
      4'd3: begin t = sx * sy; r = t[31:0]; r2 = t[63:32]; end
      4'd4: if (y != 32'd0) begin r = x / y; r2 = x % y; end else begin r = 32'd0; end
      4'd5: begin
        t = ux + uy; r = t[31:0]; uof = (t > 64'sd4294967295);
        t = sx + sy; of = (t > 64'sd2147483647) || (t < -64'sd2147483648);
      end
      4'd6: begin
        t = ux - uy; r = t[31:0]; uof = (ux < uy);
        t = sx - sy; of = (t > 64'sd2147483647) || (t < -64'sd2147483648);
      end
      4'd7:  r = x & y;
      4'd8:  r = x | y;
      4'd9:  r = x ^ y;
      4'd10: r = ~(x | y);
      4'd11: r = (sx < sy) ? 32'd1 : 32'd0;
      4'd12: r = (ux < uy) ? 32'd1 : 32'd0;
      default: r = 32'd0;
    endcase
  endtask

  task automatic alu_vec(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] er, input logic [31:0] er2,
                         input logic eof, input logic euof);
    issue(rtype(5'd0, 5'd0, 5'd0, 5'd0, 6'h20), op, x, y, 32'd0);
    tick();
    chk("alu_r", bus.ex_result, er);
    chk("alu_r2", bus.ex_r2, er2);
    chk("alu_of", 32'(bus.ex_of), 32'(eof));
    chk("alu_uof", 32'(bus.ex_uof), 32'(euof));
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] ir, x, y, im, ra, rb, er, er2, r1v, r2v, ir1;
    logic [4:0]  rs, rt, rd, dst, d1, d2;
    logic [3:0]  op;
    logic        eof, euof, eeq;

    rst = 1'b1; bus.flush = 1'b0; bus.hold = 1'b0; bus.wb_data = 32'd0;
    issue(32'd0, 4'd0, 32'd0, 32'd0, 32'd0);
    #12;
    chk("rst_mem_aluout", bus.mem_aluout, 32'd0);
    chk("rst_mem_ir", bus.mem_ir, 32'd0);
    chk("rst_stall", 32'(bus.stall), 32'd0);
    chk("rst_ex_result", bus.ex_result, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // forward from EX/MEM (select 01)
    drain();
    issue(itype(6'h08, 5'd0, 5'd1, 16'd5), 4'd5, 32'd0, 32'd0, 32'd5);
    tick();
    chk("addi_r", bus.ex_result, 32'd5);
    issue(rtype(5'd1, 5'd1, 5'd2, 5'd0, 6'h20), 4'd5, 32'd0, 32'd0, 32'd0);
    tick();
    chk("fwd01", bus.ex_result, 32'd10);

    // forward from writeback (select 10)
    drain();
    issue(itype(6'h08, 5'd0, 5'd1, 16'd5), 4'd5, 32'd0, 32'd0, 32'd5);
    tick();
    issue(32'd0, 4'd0, 32'd0, 32'd0, 32'd0);
    tick();
    issue(rtype(5'd1, 5'd1, 5'd2, 5'd0, 6'h20), 4'd5, 32'd0, 32'd0, 32'd0);
    tick();
    bus.wb_data = 32'd5;
    #1;
    chk("fwd10", bus.ex_result, 32'd10);
    bus.wb_data = 32'd0;

    // load-use
    drain();
    issue(itype(6'h23, 5'd0, 5'd3, 16'd0), 4'd5, 32'd0, 32'd0, 32'd0);
    tick();
    issue(rtype(5'd3, 5'd0, 5'd4, 5'd0, 6'h20), 4'd5, 32'd0, 32'd0, 32'd0);
    #1;
    chk("lu_stall", 32'(bus.stall), 32'd1);
    tick();
    chk("lu_stall_clr", 32'(bus.stall), 32'd0);
    chk("lu_bubble_r", bus.ex_result, 32'd0);
    tick();
    bus.wb_data = 32'd77;
    #1;
    chk("lu_fwd_wb", bus.ex_result, 32'd77);
    chk("lu_bubble_mem", bus.mem_ir, 32'd0);
    bus.wb_data = 32'd0;
    drain();
    issue(itype(6'h23, 5'd0, 5'd3, 16'd0), 4'd5, 32'd0, 32'd0, 32'd0);
    tick();
    issue(rtype(5'd0, 5'd0, 5'd4, 5'd0, 6'h20), 4'd5, 32'd0, 32'd0, 32'd0);
    #1;
    chk("lu_nostall", 32'(bus.stall), 32'd0);

    // ALU corners
    drain();
    alu_vec(4'd5, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 32'd0, 1'b1, 1'b0);
    alu_vec(4'd6, 32'd0, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b1);
    alu_vec(4'd3, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFA, 32'hFFFF_FFFF, 1'b0, 1'b0);
    alu_vec(4'd4, 32'd7, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    alu_vec(4'd1, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0);

    // operand routing
    drain();
    issue(rtype(5'd0, 5'd6, 5'd5, 5'd3, 6'h00), 4'd0, 32'd1, 32'd1, 32'd3);
    tick();
    chk("sll_imm", bus.ex_result, 32'd8);
    issue(rtype(5'd7, 5'd8, 5'd9, 5'd0, 6'h06), 4'd2, 32'd16, 32'd2, 32'd0);
    tick();
    chk("srlv", bus.ex_result, 32'd4);
    issue(itype(6'h04, 5'd1, 5'd2, 16'h0010), 4'd6, 32'h1234, 32'h1234, 32'h10);
    tick();
    chk("beq_equal", 32'(bus.ex_equal), 32'd1);
    drain();
    issue(itype(6'h08, 5'd0, 5'd0, 16'd9), 4'd5, 32'd0, 32'd0, 32'd9);
    tick();
    chk("r0_producer", bus.ex_result, 32'd9);
    issue(rtype(5'd0, 5'd0, 5'd10, 5'd0, 6'h20), 4'd5, 32'd0, 32'd0, 32'd0);
    tick();
    chk("r0_nofwd", bus.ex_result, 32'd0);

    // hold and flush
    drain();
    issue(itype(6'h08, 5'd0, 5'd11, 16'd42), 4'd5, 32'd0, 32'd0, 32'd42);
    tick();
    chk("pre_hold", bus.ex_result, 32'd42);
    bus.hold = 1'b1;
    issue(itype(6'h08, 5'd0, 5'd12, 16'd7), 4'd5, 32'd0, 32'd0, 32'd7);
    repeat (3) tick();
    chk("hold_ex", bus.ex_result, 32'd42);
    chk("hold_mem", bus.mem_aluout, 32'd0);
    bus.hold = 1'b0;
    tick();
    chk("unhold_ex", bus.ex_result, 32'd7);
    chk("unhold_mem", bus.mem_aluout, 32'd42);
    issue(itype(6'h08, 5'd0, 5'd13, 16'd99), 4'd5, 32'd0, 32'd0, 32'd99);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk("flush_ex", bus.ex_result, 32'd0);
    chk("flush_mem", bus.mem_aluout, 32'd7);
    issue(32'd0, 4'd0, 32'd0, 32'd0, 32'd0);
    tick();
    chk("flush_mem_next", bus.mem_aluout, 32'd0);
    issue(itype(6'h08, 5'd0, 5'd14, 16'd55), 4'd5, 32'd0, 32'd0, 32'd55);
    tick();
    bus.hold = 1'b1; bus.flush = 1'b1;
    issue(itype(6'h08, 5'd0, 5'd16, 16'd66), 4'd5, 32'd0, 32'd0, 32'd66);
    tick();
    chk("hold_over_flush", bus.ex_result, 32'd55);
    bus.hold = 1'b0; bus.flush = 1'b0;
    tick();
    chk("after_hold_flush", bus.ex_result, 32'd66);

    // randomized: the bench plays register file and writeback
    drain();
    d1 = 5'd0; d2 = 5'd0; r1v = 32'd0; r2v = 32'd0; ir1 = 32'd0;
    for (int k = 0; k < 300; k++) begin
      rs = 5'($urandom_range(0, 3)); rt = 5'($urandom_range(0, 3)); rd = 5'($urandom_range(0, 3));
      op = 4'($urandom_range(0, 15));
      x = pick(); y = pick(); im = pick();
      ra = (rs != 5'd0 && rs == d1) ? r1v : (rs != 5'd0 && rs == d2) ? r2v : x;
      if ($urandom_range(0, 1) == 0) begin
        ir = itype(6'h08, rs, rt, im[15:0]); dst = rt; rb = im;
      end else begin
        ir = rtype(rs, rt, rd, 5'd0, 6'h20); dst = rd;
        rb = (rt != 5'd0 && rt == d1) ? r1v : (rt != 5'd0 && rt == d2) ? r2v : y;
      end
      alu_ref(op, ra, rb, er, er2, eof, euof, eeq);
      issue(ir, op, x, y, im);
      tick();
      bus.wb_data = r2v;
      #1;
      chk("rnd_r", bus.ex_result, er);
      chk("rnd_r2", bus.ex_r2, er2);
      chk("rnd_flags", {29'd0, bus.ex_of, bus.ex_uof, bus.ex_equal}, {29'd0, eof, euof, eeq});
      chk("rnd_mem", bus.mem_aluout, r1v);
      chk("rnd_mem_ir", bus.mem_ir, ir1);
      chk("rnd_stall", 32'(bus.stall), 32'd0);
      d2 = d1; r2v = r1v; d1 = dst; r1v = er; ir1 = ir;
    end

    // asynchronous reset in the middle of a load-use stall
    drain();
    issue(itype(6'h08, 5'd0, 5'd15, 16'd3), 4'd5, 32'd0, 32'd0, 32'd3);
    tick();
    issue(itype(6'h23, 5'd0, 5'd3, 16'd0), 4'd5, 32'd0, 32'd0, 32'd0);
    tick();
    issue(rtype(5'd3, 5'd0, 5'd4, 5'd0, 6'h20), 4'd5, 32'd0, 32'd0, 32'd0);
    #1;
    chk("pre_rst_stall", 32'(bus.stall), 32'd1);
    chk("pre_rst_mem", bus.mem_aluout, 32'd3);
    rst = 1'b1;
    #1;
    chk("async_rst_mem_aluout", bus.mem_aluout, 32'd0);
    chk("async_rst_mem_ir", bus.mem_ir, 32'd0);
    chk("async_rst_stall", 32'(bus.stall), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/ex_hazard_alu.md
Name: ex_hazard_alu

Overview:
- Execute-stage slice of the 5-stage MIPS pipeline.
- Detects hazards between the ID instruction and the instructions in EX and MEM, producing a load-use stall and forwarding selects.
- Latches ID into an ID/EX register, selects the ALU operands (immediate vs register, plus forwarding), computes the ALU result, and latches it into an EX/MEM register.
- Sits between controller/register file (upstream) and data memory/writeback (downstream).

Parameters:
- none

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- id_ir  in  32  ID-stage instruction
- id_aluop  in  4  ALU opcode from controller
- id_rfd1  in  32  register-file read data 1, the value of the A-register index
- id_rfd2  in  32  register-file read data 2, the value of the B/store-data register index
- id_imm  in  32  extended immediate (shamt for shifts)
- wb_data  in  32  writeback value (forward source 10)
- flush  in  1  branch taken: bubble ID/EX
- hold  in  1  halt: freeze all registers
- stall  out  1  load-use stall request (combinational)
- ex_result  out  32  ALU result R (combinational)
- ex_r2  out  32  ALU second result
- ex_of  out  1  signed overflow
- ex_uof  out  1  unsigned overflow
- ex_equal  out  1  operand A == operand B
- mem_ir  out  32  EX/MEM instruction
- mem_aluout  out  32  EX/MEM ALU result
- mem_store_data  out  32  EX/MEM forwarded store data

Behaviour:
- Instruction fields:
  - op = ir[31:26], rs = [25:21], rt = [20:16], rd = [15:11], funct = [5:0].
  - R-type means op = 0.
- Operand register indices (also used for ALUsrcB):
  - R-type shift by immediate, funct 0/2/3: A = rt, B = immediate.
  - R-type variable shift, funct 4/6/7: A = rt, B = rs.
  - syscall (funct 0x0C): A = 2, B = 4.
  - jr (funct 8): A = rs, B unused.
  - Other R-type: A = rs, B = rt.
  - op 0x08–0x0F and 0x20–0x2B: A = rs, B = immediate.
  - beq/bne (op 4/5): A = rs, B = rt.
  - Store data register: rt for op 0x28–0x2B.
- Destination register:
  - R-type other than jr/syscall: rd.
  - op 0x08–0x0F and 0x20–0x25: rt.
  - jal (op 3): 31.
  - Otherwise none.
  - Destination 0 never matches.
- Forward selects, per source (A, B, store data), encoded as:
  - 01: the EX instruction's destination matches.
  - 10: otherwise, the MEM instruction's destination matches.
  - 00: no match.
  - An immediate B gets 00.
  - The select is latched into ID/EX and applied in EX: 00 uses the latched rfd, 01 uses mem_aluout, 10 uses wb_data.
- stall = 1 when the EX instruction is a load (op 0x20–0x25) and its destination matches any ID source actually used.
- ID/EX register (ir, aluop, rfd1, rfd2, imm, three selects):
  - On stall or flush, load a bubble (all zero).
  - Otherwise load the ID values.
- EX/MEM register: captures ex IR, ex_result and the forwarded store data every cycle.
- hold = 1 freezes both registers and overrides stall/flush.
- rst clears every register to 0. IR 0 is a nop with no destination, so all outputs become derived zeros and stall = 0.
- ALU operation (X = operand A, Y = operand B, 4-bit op), all arithmetic mod 2^32:
  - 0: SLL, X << Y[4:0].
  - 1: SRA, X >>> Y[4:0].
  - 2: SRL, X >> Y[4:0].
  - 3: MUL signed; R = low 32 bits, R2 = high 32 bits.
  - 4: DIV unsigned; R = quotient, R2 = remainder. Y = 0 gives R = R2 = 0.
  - 5: ADD.
  - 6: SUB.
  - 7: AND.
  - 8: OR.
  - 9: XOR.
  - 10: NOR.
  - 11: SLT signed, result 1/0.
  - 12: SLTU.
  - 13–15: R = 0.
- ALU flags:
  - R2 = 0 except for MUL and DIV.
  - OF: signed overflow, meaningful only for ADD/SUB, otherwise 0.
  - UOF: carry out of ADD or borrow out of SUB, otherwise 0.
  - Equal = (X == Y) for all ops.

Test Plan:
- Reset mid-run (rst = 1 asynchronously) -> mem_aluout = 0, mem_ir = 0, stall = 0 immediately, before the next clock edge.
- Forward from EX/MEM: addi $1,$0,5 followed by add $2,$1,$1 with rfd = 0 -> ex_result = 10 via select 01. With wb_data = 5 and one nop between -> select 10, result 10.
- Load-use hazard: lw $3,0($0) in EX with ID add $4,$3,$0 -> stall = 1 and the bubble enters EX. Same with ID add $4,$0,$0 -> stall = 0.
- ALU corners:
  - ADD 0x7FFFFFFF + 1 -> R = 0x80000000, OF = 1, UOF = 0.
  - SUB 0 - 1 -> R = 0xFFFFFFFF, UOF = 1.
  - MUL -2 × 3 -> R = 0xFFFFFFFA, R2 = 0xFFFFFFFF.
  - DIV 7/0 -> R = R2 = 0.
  - SRA 0x80000000 by 31 -> 0xFFFFFFFF.
- ALUsrcB and operand routing:
  - sll $5,$6,3 with rfd2 = 1 -> ex_result = 8.
  - srlv with rs = 2, rt = 16 -> 4.
  - beq with equal registers -> ex_equal = 1.
  - $0 destination never forwards.
- Freeze and flush: hold = 1 for 3 cycles -> registers unchanged. flush = 1 -> the next EX is a nop and mem_aluout = 0 one cycle later. hold and flush asserted together -> hold wins.
